// File: rtl/eda_visited_pkg.sv
// Shared types and helpers for the visited-flag bitmap: sweep FSM states,
// neighbour slot numbering and the {i, j} address split.
package eda_visited_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    localparam int SLOT8_UL = 7;
    localparam int SLOT8_U  = 6;
    localparam int SLOT8_UR = 5;
    localparam int SLOT8_L  = 4;
    localparam int SLOT8_R  = 3;
    localparam int SLOT8_DL = 2;
    localparam int SLOT8_D  = 1;
    localparam int SLOT8_DR = 0;

    localparam int SLOT4_U = 3;
    localparam int SLOT4_L = 2;
    localparam int SLOT4_R = 1;
    localparam int SLOT4_D = 0;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] j;
    } pix_t;

    // Column index occupies the low j_width bits, row index the bits above.
    function automatic pix_t split_addr(input logic [31:0] addr, input int j_width);
        pix_t       p;
        logic [31:0] jmask;
        jmask = (32'd1 << j_width) - 32'd1;
        p.j   = 16'(addr & jmask);
        p.i   = 16'(addr >> j_width);
        return p;
    endfunction

    function automatic logic in_image(input pix_t p, input int m, input int n);
        return (int'(p.i) < m) && (int'(p.j) < n);
    endfunction

endpackage

// File: rtl/eda_visited_sweep.sv
// Clear-sweep controller: walks rows 0..M-1 one per cycle, then pulses
// clear_done; busy covers both the sweep and the done cycle.
module eda_visited_sweep
    import eda_visited_pkg::*;
#(
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_req,
    output logic         busy,
    output logic         clear_done,
    output logic [M-1:0] row_clr,
    output fsm_state_t   state_o
);

    localparam int R_WIDTH = (M > 1) ? $clog2(M) : 1;

    fsm_state_t         state_q;
    logic [R_WIDTH-1:0] row_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (clear_req) begin
                        state_q <= CLEAR;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (row_q == R_WIDTH'(M - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        row_q <= row_q + R_WIDTH'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < M; r++) begin : g_row_clr
        assign row_clr[r] = (state_q == CLEAR) && (row_q == R_WIDTH'(r));
    end

    assign busy       = busy_q;
    assign clear_done = done_q;
    assign state_o    = state_q;

endmodule

// File: rtl/eda_visited_map.sv
// Visited-flag bitmap for the flood engine: centre/neighbour set ports,
// forwarded 1-cycle lookups and a row-sweep clear. EDA_VISITED_COUNT_EN adds visited_count.
module eda_visited_map
    import eda_visited_pkg::*;
#(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int CONN       = 8,
    parameter int I_WIDTH    = $clog2(M),
    parameter int J_WIDTH    = $clog2(N),
    parameter int ADDR_WIDTH = I_WIDTH + J_WIDTH,
    parameter int CNT_WIDTH  = $clog2(M * N + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear_req,
    output logic                       busy,
    output logic                       clear_done,
    input  logic                       mark_center,
    input  logic [ADDR_WIDTH-1:0]      center_addr,
    input  logic [CONN*ADDR_WIDTH-1:0] nb_addr,
    input  logic [CONN-1:0]            nb_valid,
    input  logic [CONN-1:0]            push,
    input  logic                       lookup_en,
    output logic                       visited_valid,
    output logic [CONN-1:0]            visited
`ifdef EDA_VISITED_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]       visited_count
`endif
);

    if (CONN != 4 && CONN != 8) begin : g_bad_conn
        $error("eda_visited_map: CONN must be 4 or 8");
    end
    if (ADDR_WIDTH != I_WIDTH + J_WIDTH || CNT_WIDTH < $clog2(M * N + 1)) begin : g_bad_width
        $error("eda_visited_map: inconsistent width parameters");
    end

    // Write port 0 is the centre, port k+1 is neighbour slot k.
    localparam int NP = CONN + 1;

    fsm_state_t     sweep_state;
    logic [M-1:0]   row_clr;
    logic           op_en;

    logic [M*N-1:0] flags_q, flags_d;
    logic [NP-1:0]  wr_ok;
    int             wr_idx [NP];
    logic [CONN-1:0] lk_ok;
    logic [CONN-1:0] visited_q, visited_d;
    logic           visited_valid_q;

    eda_visited_sweep #(.M(M)) u_sweep (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .row_clr    (row_clr),
        .state_o    (sweep_state)
    );

    // The request edge itself already belongs to the sweep, so no ops land on it.
    assign op_en = (sweep_state == IDLE) && !clear_req;

    always_comb begin
        pix_t px;
        px        = split_addr(32'(center_addr), J_WIDTH);
        wr_idx[0] = int'(px.i) * N + int'(px.j);
        wr_ok[0]  = op_en && mark_center && in_image(px, M, N);
        for (int k = 0; k < CONN; k++) begin
            px          = split_addr(32'(nb_addr[k*ADDR_WIDTH +: ADDR_WIDTH]), J_WIDTH);
            wr_idx[k+1] = int'(px.i) * N + int'(px.j);
            lk_ok[k]    = nb_valid[k] && in_image(px, M, N);
            wr_ok[k+1]  = op_en && push[k] && lk_ok[k];
        end
    end

    always_comb begin
        flags_d = flags_q;
        for (int r = 0; r < M; r++) begin
            if (row_clr[r]) flags_d[r*N +: N] = '0;
        end
        for (int p = 0; p < NP; p++) begin
            if (wr_ok[p]) flags_d[wr_idx[p]] = 1'b1;
        end
    end

    // Reads see this edge's writes; slots outside the image report visited.
    always_comb begin
        visited_d = '0;
        for (int k = 0; k < CONN; k++) begin
            visited_d[k] = lk_ok[k] ? flags_d[wr_idx[k+1]] : 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q         <= '0;
            visited_q       <= '0;
            visited_valid_q <= 1'b0;
        end else begin
            flags_q         <= flags_d;
            visited_valid_q <= op_en && lookup_en;
            if (op_en && lookup_en) visited_q <= visited_d;
        end
    end

    assign visited_valid = visited_valid_q;
    assign visited       = visited_q;

`ifdef EDA_VISITED_COUNT_EN
    logic                 clear_start;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

    assign clear_start = (sweep_state == IDLE) && clear_req;

    // A port counts only if its flag was clear and no lower port hits the same pixel.
    always_comb begin
        logic fresh;
        fresh   = 1'b0;
        cnt_inc = '0;
        for (int p = 0; p < NP; p++) begin
            fresh = wr_ok[p] && !flags_q[wr_idx[p]];
            for (int q = 0; q < p; q++) begin
                if (wr_ok[q] && wr_idx[q] == wr_idx[p]) fresh = 1'b0;
            end
            cnt_inc = cnt_inc + CNT_WIDTH'(fresh);
        end
        cnt_d = clear_start ? '0 : cnt_q + cnt_inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign visited_count = cnt_q;
`endif

endmodule

// File: tb/tb_eda_visited_map.sv
// Directed bench for eda_visited_map (16x16, CONN=8): vector table plus
// clear-sweep and reset-abort sequences. Count checks follow EDA_VISITED_COUNT_EN.
module tb_eda_visited_map;

    localparam int M    = 16;
    localparam int N    = 16;
    localparam int CONN = 8;
    localparam int AW   = 8;
    localparam int CW   = 9;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clear_req = 1'b0;
    logic             mark_center = 1'b0;
    logic             lookup_en = 1'b0;
    logic [AW-1:0]    center_addr = '0;
    logic [CONN*AW-1:0] nb_addr = '0;
    logic [CONN-1:0]  nb_valid = '0;
    logic [CONN-1:0]  push = '0;
    logic             busy, clear_done, visited_valid;
    logic [CONN-1:0]  visited;
`ifdef EDA_VISITED_COUNT_EN
    logic [CW-1:0]    visited_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [CONN-1:0] exp_q[$];

    always #5 clk = ~clk;

    eda_visited_map #(.M(M), .N(N), .CONN(CONN)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_req     (clear_req),
        .busy          (busy),
        .clear_done    (clear_done),
        .mark_center   (mark_center),
        .center_addr   (center_addr),
        .nb_addr       (nb_addr),
        .nb_valid      (nb_valid),
        .push          (push),
        .lookup_en     (lookup_en),
        .visited_valid (visited_valid),
        .visited       (visited)
`ifdef EDA_VISITED_COUNT_EN
        ,
        .visited_count (visited_count)
`endif
    );

    typedef struct {
        logic          mc;
        logic [7:0]    ca;
        logic [63:0]   nb;
        logic [7:0]    nv;
        logic [7:0]    pu;
        logic          le;
        logic          ev;
        logic [7:0]    evis;
        int            ecnt;
    } vec_t;

    function automatic logic [7:0] px(input int i, input int j);
        return {4'(i), 4'(j)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_count(input string name, input int exp);
`ifdef EDA_VISITED_COUNT_EN
        check(name, 32'(visited_count), 32'(exp));
`endif
    endtask

    task automatic idle_inputs();
        mark_center = 1'b0;
        push        = '0;
        lookup_en   = 1'b0;
        clear_req   = 1'b0;
        nb_valid    = '0;
    endtask

    // Row i, columns 0..7 in slots 7..0; optional push of all eight.
    task automatic row_op(input int i, input logic do_push, input logic do_look);
        nb_addr   = {px(i,0), px(i,1), px(i,2), px(i,3), px(i,4), px(i,5), px(i,6), px(i,7)};
        nb_valid  = 8'hFF;
        push      = do_push ? 8'hFF : 8'h00;
        lookup_en = do_look;
        tick();
        idle_inputs();
    endtask

    task automatic run_sweep(input string tag);
        int n, done_cycle, done_pulses, vv_bad;
        n = 0; done_cycle = 0; done_pulses = 0; vv_bad = 0;
        idle_inputs();
        clear_req = 1'b1;
        tick();
        while (busy && n < 40) begin
            n++;
            if (clear_done) begin
                done_pulses++;
                done_cycle = n;
            end
            if (visited_valid) vv_bad++;
            // Writes, lookups and a second clear_req during busy must all be ignored.
            nb_addr   = {px(12,0), px(12,1), px(12,2), px(12,3), px(12,4), px(12,5), px(12,6), px(12,7)};
            nb_valid  = 8'hFF;
            push      = 8'hFF;
            mark_center = 1'b1;
            center_addr = px(13, 13);
            lookup_en = 1'b1;
            clear_req = 1'b1;
            tick();
        end
        idle_inputs();
        check({tag, "_busy_cycles"}, 32'(n), 32'd17);
        check({tag, "_done_cycle"}, 32'(done_cycle), 32'd17);
        check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
        check({tag, "_valid_during_busy"}, 32'(vv_bad), 32'd0);
        tick();
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(clear_done), 32'd0);
        check_count({tag, "_count_after"}, 0);
    endtask

    vec_t vecs [10];

    initial begin
        logic [63:0] nb88, nb34, nbc;
        nb88 = {px(7,7), px(7,8), px(7,9), px(8,7), px(8,9), px(9,7), px(9,8), px(9,9)};
        nb34 = {px(2,3), px(2,4), px(2,5), px(3,3), px(3,5), px(4,3), px(4,4), px(4,5)};
        nbc  = {px(15,15), px(15,0), px(15,1), px(0,15), px(0,1), px(1,0), px(1,1), px(1,2)};
        //           mc    ca         nb      nv     pu     le    ev    evis   cnt
        vecs[0] = '{1'b0, px(0,0),   nb88,   8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[1] = '{1'b0, px(0,0),   nb88,   8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 0};
        vecs[2] = '{1'b1, px(3,4),   nb34,   8'hFF, 8'h08, 1'b1, 1'b1, 8'h08, 2};
        vecs[3] = '{1'b0, px(0,0),
                    {px(3,4), px(9,9), px(9,9), px(9,9), px(3,5), px(9,9), px(9,9), px(3,4)},
                                         8'hFF, 8'h00, 1'b1, 1'b1, 8'h89, 2};
        vecs[4] = '{1'b1, px(0,0),
                    {px(0,0), px(0,0), px(9,9), px(9,9), px(9,9), px(9,9), px(9,9), px(9,9)},
                                         8'hFF, 8'hC0, 1'b1, 1'b1, 8'hC0, 3};
        vecs[5] = '{1'b0, px(0,0),   nbc,    8'h0F, 8'hFF, 1'b1, 1'b1, 8'hFF, 7};
        vecs[6] = '{1'b0, px(0,0),   nbc,    8'hFF, 8'h00, 1'b1, 1'b1, 8'h0F, 7};
        vecs[7] = '{1'b0, px(0,0),   nb88,   8'h00, 8'hFF, 1'b1, 1'b1, 8'hFF, 7};
        vecs[8] = '{1'b0, px(0,0),   nb88,   8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 7};
        vecs[9] = '{1'b0, px(0,0),
                    {px(3,4), px(3,5), px(0,0), px(0,1), px(1,0), px(1,1), px(1,2), px(9,9)},
                                         8'hFF, 8'h00, 1'b1, 1'b1, 8'hFE, 7};

        // Reset state, both before and after the first edges.
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(clear_done), 32'd0);
        check("rst_valid", 32'(visited_valid), 32'd0);
        check("rst_visited", 32'(visited), 32'd0);
        check_count("rst_count", 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 10; v++) begin
            mark_center = vecs[v].mc;
            center_addr = vecs[v].ca;
            nb_addr     = vecs[v].nb;
            nb_valid    = vecs[v].nv;
            push        = vecs[v].pu;
            lookup_en   = vecs[v].le;
            if (vecs[v].le) exp_q.push_back(vecs[v].evis);
            tick();
            idle_inputs();
            check($sformatf("vec%0d_valid", v), 32'(visited_valid), 32'(vecs[v].ev));
            if (vecs[v].ev && exp_q.size() > 0)
                check($sformatf("vec%0d_visited", v), 32'(visited), 32'(exp_q.pop_front()));
            else
                check($sformatf("vec%0d_visited_hold", v), 32'(visited), 32'(vecs[v].evis));
            check_count($sformatf("vec%0d_count", v), vecs[v].ecnt);
        end
        tick();
        check("valid_drops", 32'(visited_valid), 32'd0);

        // Fill two more rows, then sweep.
        row_op(10, 1'b1, 1'b0);
        row_op(11, 1'b1, 1'b0);
        check_count("fill_count", 23);
        run_sweep("sweep1");
        for (int r = 10; r <= 12; r++) begin
            row_op(r, 1'b0, 1'b1);
            check($sformatf("cleared_row%0d", r), 32'(visited), 32'd0);
        end
        nb_addr  = {px(3,4), px(3,5), px(0,0), px(0,1), px(1,0), px(1,1), px(1,2), px(13,13)};
        nb_valid = 8'hFF;
        lookup_en = 1'b1;
        tick();
        idle_inputs();
        check("cleared_early_flags", 32'(visited), 32'd0);
        check("cleared_valid", 32'(visited_valid), 32'd1);

        // Abort a sweep with reset while row 5 is being cleared.
        row_op(14, 1'b1, 1'b0);
        check_count("abort_fill_count", 8);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(clear_done), 32'd0);
        check("abort_valid", 32'(visited_valid), 32'd0);
        check_count("abort_count", 0);
        tick();
        reset_n = 1'b1;
        tick();
        row_op(14, 1'b0, 1'b1);
        check("abort_row14", 32'(visited), 32'd0);
        run_sweep("sweep2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
